// File: rtl/alu_serial.sv
// alu_serial: multi-cycle ALU behind a valid/ready request/response pair.
// Logic, add/sub and compare ops finish in one cycle; shifts use a one-bit
// serial shifter that runs for shamt cycles before the result is presented.
module alu_serial #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ALUcontrol,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   localparam int SW = $clog2(WIDTH);
   localparam logic [SW-1:0] CNT_ONE = SW'(1);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_SRA  = 4'b1001;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] result_q;
   logic             illegal_q;
   logic [WIDTH-1:0] shreg;
   logic [SW-1:0]    cnt;

   logic             accept;
   logic [SW-1:0]    shamt_in;
   logic             is_shift;
   logic [WIDTH-1:0] calc;
   logic             calc_illegal;
   logic [WIDTH-1:0] shift_next;

   // Handshake outputs depend only on state (and out_ready while holding a result).
   always_comb begin
      in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
      out_valid = (state == DONE);
      accept    = in_valid && in_ready;
      result    = result_q;
      zero      = (result_q == '0);
      illegal   = illegal_q;
   end

   // Single-cycle evaluation of the incoming request; shifts pass a through for shamt = 0.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      calc         = '0;
      calc_illegal = 1'b0;
      shamt_in     = b[SW-1:0];
      is_shift     = (ALUcontrol == OP_SLL) || (ALUcontrol == OP_SRL) || (ALUcontrol == OP_SRA);
      case (ALUcontrol)
         OP_ADD:  calc = a + b;
         OP_SUB:  calc = a - b;
         OP_AND:  calc = a & b;
         OP_OR:   calc = a | b;
         OP_XOR:  calc = a ^ b;
         OP_SLT:  calc = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: calc = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SLL, OP_SRL, OP_SRA: calc = a;
         default: calc_illegal = 1'b1;
      endcase
   end

   // One bit position of the serial shifter; SRA keeps replicating the original sign bit.
   always_comb begin
      shift_next = shreg;
      case (op_q)
         OP_SLL:  shift_next = {shreg[WIDTH-2:0], 1'b0};
         OP_SRL:  shift_next = {1'b0, shreg[WIDTH-1:1]};
         default: shift_next = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
      endcase
   end

   // Control FSM with the result, flag and shifter registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         state     <= IDLE;
         op_q      <= '0;
         result_q  <= '0;
         illegal_q <= 1'b0;
         // NOTE: shifter and counter are cleared too, so a discarded shift leaves nothing behind.
         shreg     <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            SHIFT: begin
               shreg <= shift_next;
               cnt   <= cnt - 1'b1;
               if (cnt == CNT_ONE) begin
                  result_q  <= shift_next;
                  illegal_q <= 1'b0;
                  state     <= DONE;
               end
            end
            default: begin
               // IDLE and DONE share the accept path; DONE also accepts while releasing.
               if (accept) begin
                  op_q <= ALUcontrol;
                  if (is_shift && (shamt_in != '0)) begin
                     shreg <= a;
                     cnt   <= shamt_in;
                     state <= SHIFT;
                  end else begin
                     result_q  <= calc;
                     illegal_q <= calc_illegal;
                     state     <= DONE;
                  end
               end else if ((state == DONE) && out_ready) begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: table-driven directed vectors, hand-written handshake and
// reset sequences, and random ops against a behavioural model of the ALU.
module tb_alu_serial;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  ALUcontrol;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   int checks   = 0;
   int failures = 0;

   alu_serial #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .ALUcontrol(ALUcontrol), .a(a), .b(b), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Behavioural reference: {illegal, result} straight from the encoding table.
   function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      int sh;
      logic signed [31:0] sx;
      logic signed [31:0] sy;
      sh = int'(y[4:0]);
      sx = x;
      sy = y;
      case (op)
         4'd0: return {1'b0, x + y};
         4'd1: return {1'b0, x - y};
         4'd2: return {1'b0, x & y};
         4'd3: return {1'b0, x | y};
         4'd4: return {1'b0, x ^ y};
         4'd5: return {1'b0, x << sh};
         4'd6: return {1'b0, x >> sh};
         4'd7: return {1'b0, (sx < sy) ? 32'd1 : 32'd0};
         4'd8: return {1'b0, (x < y) ? 32'd1 : 32'd0};
         4'd9: return {1'b0, 32'(sx >>> sh)};
         default: return {1'b1, 32'd0};
      endcase
   endfunction

   function automatic int ref_latency(input logic [3:0] op, input logic [31:0] y);
      if ((op == 4'd5 || op == 4'd6 || op == 4'd9) && y[4:0] != 5'd0) return 1 + int'(y[4:0]);
      return 1;
   endfunction

   // Issue one request, wait (bounded) for the response and optionally release it.
   task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input bit rel,
                         output logic [31:0] r, output logic z, output logic ill, output int lat);
      bit ready_leak;
      @(negedge clk);
      check({name, "_in_ready"}, 32'(in_ready), 32'd1);
      ALUcontrol = op; a = av; b = bv; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      ALUcontrol = 4'($urandom); a = $urandom; b = $urandom;
      lat = 0;
      ready_leak = 1'b0;
      while (1) begin
         @(negedge clk);
         lat++;
         if (out_valid === 1'b1 || lat > 100) break;
         if (in_ready !== 1'b0) ready_leak = 1'b1;
      end
      check({name, "_busy_in_ready"}, 32'(ready_leak), 32'd0);
      r = result; z = zero; ill = illegal;
      if (rel) begin
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
      end
   endtask

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] av;
      logic [31:0] bv;
      logic [31:0] res;
      logic        ill;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [31:0] r;
      logic        z;
      logic        ill;
      int          lat;
      bit          bad_res, bad_rdy, bad_vld;
      logic [32:0] m;

      vecs.push_back('{"add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1,          32'h8000_0000, 1'b0, 1});
      vecs.push_back('{"sub_eq",  4'd1, 32'd5,         32'd5,          32'h0000_0000, 1'b0, 1});
      vecs.push_back('{"slt",     4'd7, 32'hFFFF_FFFF, 32'd1,          32'h0000_0001, 1'b0, 1});
      vecs.push_back('{"sltu",    4'd8, 32'hFFFF_FFFF, 32'd1,          32'h0000_0000, 1'b0, 1});
      vecs.push_back('{"xor",     4'd4, 32'hF0F0_F0F0, 32'hFFFF_FFFF,  32'h0F0F_0F0F, 1'b0, 1});
      vecs.push_back('{"sra31",   4'd9, 32'h8000_0000, 32'd31,         32'hFFFF_FFFF, 1'b0, 32});
      vecs.push_back('{"srl31",   4'd6, 32'h8000_0000, 32'd31,         32'h0000_0001, 1'b0, 32});
      vecs.push_back('{"sll_sh0", 4'd5, 32'd1,         32'h0000_0020,  32'h0000_0001, 1'b0, 1});
      vecs.push_back('{"sll_hi",  4'd5, 32'd3,         32'h0000_0025,  32'h0000_0060, 1'b0, 6});
      vecs.push_back('{"sra_pos", 4'd9, 32'h7000_0000, 32'd4,          32'h0700_0000, 1'b0, 5});
      vecs.push_back('{"srl1",    4'd6, 32'hF000_0000, 32'd1,          32'h7800_0000, 1'b0, 2});
      vecs.push_back('{"ill_c",   4'hC, 32'h1234_5678, 32'h9ABC_DEF0,  32'h0000_0000, 1'b1, 1});
      vecs.push_back('{"add_ok",  4'd0, 32'd2,         32'd3,          32'h0000_0005, 1'b0, 1});
      vecs.push_back('{"ill_f",   4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0000_0000, 1'b1, 1});

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      ALUcontrol = '0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_result",    result,         32'd0);
      check("rst_zero",      32'(zero),      32'd1);
      check("rst_illegal",   32'(illegal),   32'd0);

      // Directed vector table.
      foreach (vecs[i]) begin
         run_op(vecs[i].name, vecs[i].op, vecs[i].av, vecs[i].bv, 1'b1, r, z, ill, lat);
         check({vecs[i].name, "_result"},  r,            vecs[i].res);
         check({vecs[i].name, "_zero"},    32'(z),       32'(vecs[i].res == 32'd0));
         check({vecs[i].name, "_illegal"}, 32'(ill),     32'(vecs[i].ill));
         check({vecs[i].name, "_latency"}, 32'(lat),     32'(vecs[i].lat));
      end

      // Backpressure: AND held for 5 cycles, then release with a same-cycle OR accept.
      run_op("bp_and", 4'd2, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, r, z, ill, lat);
      check("bp_and_result", r, 32'h0000_0F00);
      bad_res = 1'b0; bad_rdy = 1'b0; bad_vld = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (result !== 32'h0000_0F00 || zero !== 1'b0 || illegal !== 1'b0) bad_res = 1'b1;
         if (in_ready !== 1'b0) bad_rdy = 1'b1;
         if (out_valid !== 1'b1) bad_vld = 1'b1;
      end
      check("bp_hold_outputs",  32'(bad_res), 32'd0);
      check("bp_hold_in_ready", 32'(bad_rdy), 32'd0);
      check("bp_hold_valid",    32'(bad_vld), 32'd0);
      out_ready = 1'b1; in_valid = 1'b1; ALUcontrol = 4'd3; a = 32'h0000_FF00; b = 32'h0000_0FF0;
      #1;
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      check("bp_or_valid",  32'(out_valid), 32'd1);
      check("bp_or_result", result,         32'h0000_FFF0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;

      // Throughput: one ADD accepted per cycle with out_ready held high.
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k > 0) begin
            check("tp_valid",  32'(out_valid), 32'd1);
            check("tp_result", result, 32'(k - 1) * 32'h0101_0101 + 32'd7);
         end
         check("tp_in_ready", 32'(in_ready), 32'd1);
         in_valid = 1'b1; ALUcontrol = 4'd0; a = 32'(k) * 32'h0101_0101; b = 32'd7;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("tp_last_result", result, 32'd5 * 32'h0101_0101 + 32'd7);
      @(posedge clk);
      #1;
      out_ready = 1'b0;

      // Reset during SHIFT cycle 3 of SLL shamt=10 discards the operation.
      @(negedge clk);
      in_valid = 1'b1; ALUcontrol = 4'd5; a = 32'h0000_0003; b = 32'd10;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_shift_busy", 32'(in_ready), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_valid",    32'(out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready),  32'd1);
      check("mid_rst_result",   result,         32'd0);
      check("mid_rst_zero",     32'(zero),      32'd1);
      reset = 1'b0;
      out_ready = 1'b1;
      bad_vld = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || result !== 32'd0) bad_vld = 1'b1;
      end
      check("mid_rst_no_stale", 32'(bad_vld), 32'd0);
      out_ready = 1'b0;

      // Random ops against the reference model.
      for (int n = 0; n < 150; n++) begin
         logic [3:0]  op;
         logic [31:0] av, bv;
         op = 4'($urandom_range(0, 15));
         av = $urandom;
         bv = $urandom;
         if (n % 4 == 0) av = 32'h8000_0000 | av;
         m = ref_alu(op, av, bv);
         run_op("rnd", op, av, bv, 1'b1, r, z, ill, lat);
         check("rnd_result",  r,         m[31:0]);
         check("rnd_zero",    32'(z),    32'(m[31:0] == 32'd0));
         check("rnd_illegal", 32'(ill),  32'(m[32]));
         check("rnd_latency", 32'(lat),  32'(ref_latency(op, bv)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_serial.md
# alu_serial

Multi-cycle ALU that executes the 4-bit ALU control codes produced by the control unit's ALU decoder, for the planned multi-cycle variant of the core. Operands and the control code enter through a valid/ready handshake. The result leaves through a second valid/ready handshake. Logic, add/sub and compare ops complete in one cycle. Shifts run on a serial shifter, one bit position per cycle, to save area.

## Interface
- WIDTH, 32, datapath width; must be a power of two ≥ 8; shift amount width SW = log2(WIDTH)
- clk  input  1  rising-edge clock; the block's only clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request this cycle
- ALUcontrol  input  4  operation code, sampled on accept
- a  input  WIDTH  operand A (shift source), sampled on accept
- b  input  WIDTH  operand B; b[SW-1:0] is the shift amount, sampled on accept
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  operation result
- zero  output  1  result == 0
- illegal  output  1  accepted code was not a defined encoding; qualified by out_valid

## Operation
- Encodings:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLL, 0110 SRL, 0111 SLT (signed), 1000 SLTU, 1001 SRA
  - 1010–1111 illegal: result = 0, zero = 1, illegal = 1
- ADD/SUB wrap modulo 2^WIDTH; no overflow or carry outputs.
- SLT/SLTU return {WIDTH-1 zeros, lt}.
- Accept happens when in_valid && in_ready. On accept, the block latches ALUcontrol, a and b[SW-1:0].
- States: IDLE, SHIFT, DONE.
  - IDLE: in_ready = 1.
    - Accept of a non-shift op, or a shift with shamt = 0: compute into the result register, go to DONE.
    - Accept of a shift with shamt > 0: load a into the shift register and shamt into a down-counter, go to SHIFT.
  - SHIFT: each cycle shift one position and decrement the counter.
    - SLL fills with 0. SRL fills with 0. SRA fills with the original a[WIDTH-1].
    - When the counter reaches 0 after the shift, go to DONE. The SHIFT state lasts exactly shamt cycles.
    - in_ready = 0 in SHIFT.
  - DONE: out_valid = 1; result, zero and illegal are held stable until out_ready.
    - If out_ready: release the result. A simultaneous accept is permitted (in_ready = out_ready in DONE) and follows the IDLE accept rules. Otherwise go to IDLE.
- Bits of b above SW-1 are ignored for shifts.
- zero is derived from the registered result.

## Timing
- Reset, in any state including mid-shift:
  - Next state is IDLE; any in-flight operation is discarded with no output.
  - Reset values: out_valid = 0, in_ready = 1 (combinational from IDLE), result = 0, zero = 1, illegal = 0.
- in_ready and out_valid are functions of state (and out_ready in DONE) only. There is no combinational path from in_valid.
- Latency, from the accept edge to the first cycle out_valid = 1:
  - 1 cycle for non-shift ops and shamt = 0.
  - 1 + shamt cycles for shifts.
- Throughput: one non-shift op per cycle when out_ready is held high (back-to-back accept in DONE).
- Backpressure: with out_ready = 0, DONE holds indefinitely, in_ready = 0, and outputs do not change.
- Inputs a, b and ALUcontrol may change freely after accept without affecting the in-flight op.
- Maximum shift: shamt = WIDTH-1 takes WIDTH-1 SHIFT cycles. No other limit applies.

## Test plan
- Reset, then ADD a=0x7FFFFFFF, b=1 → out_valid one cycle after accept, result 0x80000000, zero=0. Then SUB a=5, b=5 → result 0, zero=1.
- SLT a=0xFFFFFFFF, b=1 → 1. SLTU with the same operands → 0. XOR a=0xF0F0F0F0, b=0xFFFFFFFF → 0x0F0F0F0F.
- SRA a=0x80000000, b=31 → in_ready low for 31 SHIFT cycles, out_valid on cycle 32 after accept, result 0xFFFFFFFF. SRL with the same operands → 0x00000001. SLL a=1, b=0x20 (shamt 0) → result 1 after 1 cycle.
- Backpressure: out_ready=0 for 5 cycles after AND a=0xFF00, b=0x0FF0 → result held at 0x0F00, in_ready=0 throughout. Raise out_ready together with a new OR request → new accept in the same cycle; next result 0xFFF0 for OR a=0xFF00, b=0x0FF0.
- Reset asserted at SHIFT cycle 3 of SLL shamt=10 → next cycle IDLE, out_valid=0, result=0. No stale result appears afterwards.
- ALUcontrol=1100 → result 0, zero=1, illegal=1 with out_valid. The following legal ADD reports illegal=0.
